// File: rtl/ysyx_23060111_mdu_if.sv
// Request/response bundle for the M-extension multiply/divide unit.
// The master drives requests and flush; the slave returns the tagged result.
interface ysyx_23060111_mdu_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  src1;
    logic [XLEN-1:0]  src2;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_wdata;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output flush, in_valid, funct3, src1, src2, in_tag, out_ready,
        input  in_ready, out_valid, out_wdata, out_tag
    );

    modport slave (
        input  flush, in_valid, funct3, src1, src2, in_tag, out_ready,
        output in_ready, out_valid, out_wdata, out_tag
    );
endinterface

// File: rtl/ysyx_23060111_mdu.sv
// RV M-extension multiply/divide unit: iterative shift-add multiplier and restoring divider.
// Define YSYX_23060111_MDU_FAST_MUL_EN to compute multiplies in one cycle instead.
module ysyx_23060111_mdu #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ysyx_23060111_mdu_if.slave   mdu
);
    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  MOST_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [2:0]          r_op;
    logic [TAG_W-1:0]    r_tag;
    logic                r_neg_res;
    logic                r_neg_rem;
    logic [2*XLEN-1:0]   r_acc;
    logic [XLEN-1:0]     r_mcand;
    logic [CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]     r_wdata;
    logic [TAG_W-1:0]    r_out_tag;

    logic                w_accept;
    logic                w_is_div;
    logic                w_a_signed;
    logic                w_b_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_mag_a;
    logic [XLEN-1:0]     w_mag_b;
    logic                w_div_zero;
    logic                w_div_ovf;
    logic                w_special;
    logic [XLEN-1:0]     w_special_res;
    logic                w_direct;

    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;
    logic [XLEN:0]       w_div_diff;
    logic [2*XLEN-1:0]   w_div_next;
    logic [2*XLEN-1:0]   w_acc_next;

    // Sign-fix the unsigned magnitude result; shared by the iterative and fast paths
    function automatic logic [XLEN-1:0] f_result(
        input logic [2:0]        op,
        input logic              neg_res,
        input logic              neg_rem,
        input logic [2*XLEN-1:0] acc
    );
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = neg_res ? -acc : acc;
        quo  = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        if (op[2])
            f_result = op[1] ? rem : quo;
        else if (op[1:0] == 2'b00)
            f_result = prod[XLEN-1:0];
        else
            f_result = prod[2*XLEN-1:XLEN];
    endfunction

    assign w_accept   = (r_state == IDLE) && mdu.in_valid && !mdu.flush;
    assign w_is_div   = mdu.funct3[2];
    assign w_a_signed = w_is_div ? !mdu.funct3[0]
                                 : (mdu.funct3[1:0] == 2'b01) || (mdu.funct3[1:0] == 2'b10);
    assign w_b_signed = w_is_div ? !mdu.funct3[0] : (mdu.funct3[1:0] == 2'b01);
    assign w_a_neg    = w_a_signed && mdu.src1[XLEN-1];
    assign w_b_neg    = w_b_signed && mdu.src2[XLEN-1];
    assign w_mag_a    = w_a_neg ? -mdu.src1 : mdu.src1;
    assign w_mag_b    = w_b_neg ? -mdu.src2 : mdu.src2;

    assign w_div_zero = w_is_div && (mdu.src2 == '0);
    assign w_div_ovf  = w_is_div && !mdu.funct3[0] && (mdu.src1 == MOST_NEG) && (mdu.src2 == '1);
    assign w_special  = w_div_zero || w_div_ovf;

    always_comb begin
        w_special_res = '0;
        if (w_div_zero)
            w_special_res = mdu.funct3[1] ? mdu.src1 : '1;
        else if (w_div_ovf)
            w_special_res = mdu.funct3[1] ? '0 : mdu.src1;
    end

`ifdef YSYX_23060111_MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_prod;
    assign w_fast_prod = {{XLEN{1'b0}}, w_mag_a} * {{XLEN{1'b0}}, w_mag_b};
    assign w_direct    = w_special || !w_is_div;
`else
    assign w_direct    = w_special;
`endif

    // Multiply step: low half of r_acc holds the remaining multiplier bits, high half the partial product
    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_mcand} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: high half is the partial remainder, low half shifts dividend out and quotient in
    assign w_div_diff = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_mcand};
    assign w_div_next = w_div_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = w_direct ? DONE : BUSY;
            BUSY: if (r_cnt == LAST_STEP) w_state_next = DONE;
            DONE: if (mdu.out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (mdu.flush)
            w_state_next = IDLE;
    end

    always_comb begin
        mdu.in_ready  = 1'b0;
        mdu.out_valid = 1'b0;
        case (r_state)
            IDLE:    mdu.in_ready  = 1'b1;
            DONE:    mdu.out_valid = 1'b1;
            default: ;
        endcase
    end

    assign mdu.out_wdata = r_wdata;
    assign mdu.out_tag   = r_out_tag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op      <= '0;
            r_tag     <= '0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_acc     <= '0;
            r_mcand   <= '0;
            r_cnt     <= '0;
            r_wdata   <= '0;
            r_out_tag <= '0;
        end else if (mdu.flush) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_op      <= mdu.funct3;
            r_tag     <= mdu.in_tag;
            r_neg_res <= w_a_neg ^ w_b_neg;
            r_neg_rem <= w_a_neg;
            r_cnt     <= '0;
            r_acc     <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_mcand   <= w_is_div ? w_mag_b : w_mag_a;
            if (w_special) begin
                r_wdata   <= w_special_res;
                r_out_tag <= mdu.in_tag;
            end
`ifdef YSYX_23060111_MDU_FAST_MUL_EN
            else if (!w_is_div) begin
                r_wdata   <= f_result(mdu.funct3, w_a_neg ^ w_b_neg, w_a_neg, w_fast_prod);
                r_out_tag <= mdu.in_tag;
            end
`endif
        end else if (r_state == BUSY) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST_STEP) begin
                r_wdata   <= f_result(r_op, r_neg_res, r_neg_rem, w_acc_next);
                r_out_tag <= r_tag;
            end
        end
    end
endmodule

// File: tb/tb_ysyx_23060111_mdu.sv
// Scoreboard bench for ysyx_23060111_mdu: directed vectors, latency counted from the accept cycle.
// A monitor pops the expected result each time out_valid rises.
module tb_ysyx_23060111_mdu;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
`ifdef YSYX_23060111_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    typedef struct {
        logic [XLEN-1:0]  data;
        logic [TAG_W-1:0] tag;
        int               due;
        int               id;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_chk;
    int   n_fail;
    logic prev_valid;
    exp_t exp_q[$];

    ysyx_23060111_mdu_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

    ysyx_23060111_mdu #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mdu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.out_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_valid: got out_valid=1 wdata=0x%0h, expected no result", bus.out_wdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                $display("txn %0d: wdata=0x%08h tag=%0d latency=%0d", e.id, bus.out_wdata, bus.out_tag, cyc - (e.due - 0));
                chk($sformatf("txn%0d_wdata", e.id), 64'(bus.out_wdata), 64'(e.data));
                chk($sformatf("txn%0d_tag", e.id), 64'(bus.out_tag), 64'(e.tag));
                chk($sformatf("txn%0d_latency", e.id), 64'(cyc), 64'(e.due));
            end
        end
        prev_valid = bus.out_valid;
    end

    int txn_id;

    task automatic issue(input logic [2:0] f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [TAG_W-1:0] t, input logic [XLEN-1:0] expv, input int lat,
                         input bit expect_out);
        int n;
        @(negedge clk);
        bus.funct3   = f;
        bus.src1     = a;
        bus.src2     = b;
        bus.in_tag   = t;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            chk("accept_timeout", 64'(bus.in_ready), 64'd1);
            bus.in_valid = 1'b0;
            return;
        end
        txn_id++;
        if (expect_out)
            exp_q.push_back('{data: expv, tag: t, due: cyc + lat, id: txn_id});
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !bus.in_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        bit seen;
        cyc = 0;
        n_chk = 0;
        n_fail = 0;
        txn_id = 0;
        prev_valid = 1'b0;
        rst_n = 1'b0;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.funct3 = 3'b000;
        bus.src1 = '0;
        bus.src2 = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_wdata", 64'(bus.out_wdata), 64'd0);
        chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        // Multiplies
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h4000_0000, MUL_LAT, 1'b1);
        issue(3'b000, 32'd7,         32'hFFFF_FFFD, 5'd2, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'hFFFF_FFFE, MUL_LAT, 1'b1);
        issue(3'b010, 32'hFFFF_FFFF, 32'd2,         5'd4, 32'hFFFF_FFFF, MUL_LAT, 1'b1);
        issue(3'b010, 32'd2,         32'hFFFF_FFFF, 5'd5, 32'h0000_0001, MUL_LAT, 1'b1);
        // Signed and unsigned divides
        issue(3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        issue(3'b110, 32'hFFFF_FFF9, 32'd2,         5'd9, 32'hFFFF_FFFF, DIV_LAT, 1'b1);
        issue(3'b100, 32'd7,         32'hFFFF_FFFE, 5'd6, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        issue(3'b110, 32'd7,         32'hFFFF_FFFE, 5'd6, 32'h0000_0001, DIV_LAT, 1'b1);
        issue(3'b101, 32'd100,       32'd7,         5'd7, 32'd14,        DIV_LAT, 1'b1);
        issue(3'b111, 32'd100,       32'd7,         5'd7, 32'd2,         DIV_LAT, 1'b1);
        issue(3'b101, 32'hFFFF_FFFF, 32'h10,        5'd8, 32'h0FFF_FFFF, DIV_LAT, 1'b1);
        issue(3'b111, 32'hFFFF_FFFF, 32'h10,        5'd8, 32'h0000_000F, DIV_LAT, 1'b1);
        // Divide by zero and signed overflow short-cuts
        issue(3'b101, 32'h1234,      32'd0,         5'd10, 32'hFFFF_FFFF, 1, 1'b1);
        issue(3'b111, 32'h1234,      32'd0,         5'd11, 32'h0000_1234, 1, 1'b1);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1, 1'b1);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, 1, 1'b1);
        wait_idle();

        // Consumer stall: result and handshake must hold for 10 cycles
        bus.out_ready = 1'b0;
        issue(3'b000, 32'd6, 32'd7, 5'd3, 32'd42, MUL_LAT, 1'b1);
        begin
            int n;
            n = 0;
            while (!bus.out_valid && n < 100) begin
                @(negedge clk);
                n++;
            end
        end
        chk("stall_valid_seen", 64'(bus.out_valid), 64'd1);
        begin
            bit bad;
            bad = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (!bus.out_valid || bus.out_wdata !== 32'd42 || bus.out_tag !== 5'd3 || bus.in_ready)
                    bad = 1'b1;
            end
            chk("stall_hold_stable", 64'(bad), 64'd0);
        end
        bus.out_ready = 1'b1;
        chk("handshake_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("post_handshake_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_handshake_valid", 64'(bus.out_valid), 64'd0);
        chk("post_handshake_wdata_kept", 64'(bus.out_wdata), 64'd42);

        // Flush at BUSY cycle 12: no result may appear
        issue(3'b101, 32'd100, 32'd7, 5'd15, 32'd0, 0, 1'b0);
        repeat (12) @(negedge clk);
        chk("busy_before_flush", 64'(bus.in_ready), 64'd0);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid) seen = 1'b1;
        end
        chk("flush_no_valid", 64'(seen), 64'd0);

        // Request presented together with flush is dropped
        @(negedge clk);
        bus.funct3 = 3'b000;
        bus.src1 = 32'd1;
        bus.src2 = 32'd1;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        chk("flush_blocks_accept", 64'(bus.in_ready), 64'd1);

        // Reset in the middle of BUSY
        issue(3'b000, 32'd3, 32'd5, 5'd20, 32'd0, 0, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midbusy_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("midbusy_rst_wdata", 64'(bus.out_wdata), 64'd0);
        chk("midbusy_rst_tag", 64'(bus.out_tag), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midbusy_rst_in_ready", 64'(bus.in_ready), 64'd1);

        issue(3'b100, 32'd7, 32'hFFFF_FFFE, 5'd21, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d, expected completion", cyc);
        $fatal(1, "timeout");
    end
endmodule
